// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: steps the single-cycle datapath through FETCH/EXECUTE/MEMORY,
// gates decoded write enables so each instruction commits once, and tracks halt/timeout/instret.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT   = 16,
    parameter int INSTRET_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     imem_req,
    input  logic                     imem_ready,
    input  logic [31:0]              imem_rdata,
    output logic [31:0]              instruction,
    input  logic                     dec_memory_we,
    input  logic                     dec_load_memory,
    input  logic                     dec_reg_we,
    output logic                     dmem_req,
    output logic                     dmem_we,
    input  logic                     dmem_ready,
    output logic                     reg_we,
    output logic                     pc_we,
    output logic                     retire,
    output logic [INSTRET_WIDTH-1:0] instret,
    output logic                     halted,
    output logic                     error
);

    localparam logic [31:0] NOP_INSN    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;
    // Counter only ever needs to reach MEM_TIMEOUT-1.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEMORY  = 3'd3,
        S_HALT    = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    state_t                   state_reg, state_next;
    logic [31:0]              ir_reg, ir_next;
    logic [WAIT_W-1:0]        wait_reg, wait_next;
    logic [INSTRET_WIDTH-1:0] instret_reg;
    logic                     timeout_hit;

    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_reg == WAIT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            ir_reg      <= NOP_INSN;
            wait_reg    <= '0;
            instret_reg <= '0;
        end else begin
            state_reg <= state_next;
            ir_reg    <= ir_next;
            wait_reg  <= wait_next;
            if (retire) begin
                instret_reg <= instret_reg + INSTRET_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        ir_next    = ir_reg;
        wait_next  = wait_reg;
        case (state_reg)
            S_IDLE: begin
                state_next = S_FETCH;
                wait_next  = '0;
            end
            S_FETCH: begin
                // A ready in the last allowed cycle still completes the fetch.
                if (imem_ready) begin
                    ir_next    = imem_rdata;
                    state_next = S_EXECUTE;
                end else if (timeout_hit) begin
                    state_next = S_ERROR;
                end else begin
                    wait_next = wait_reg + WAIT_W'(1);
                end
            end
            S_EXECUTE: begin
                wait_next = '0;
                if (ir_reg == EBREAK_INSN) begin
                    state_next = S_HALT;
                end else if (dec_memory_we || dec_load_memory) begin
                    state_next = S_MEMORY;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MEMORY: begin
                if (dmem_ready) begin
                    state_next = S_FETCH;
                    wait_next  = '0;
                end else if (timeout_hit) begin
                    state_next = S_ERROR;
                end else begin
                    wait_next = wait_reg + WAIT_W'(1);
                end
            end
            S_HALT:  state_next = S_HALT;
            S_ERROR: state_next = S_ERROR;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        pc_we    = 1'b0;
        retire   = 1'b0;
        halted   = 1'b0;
        error    = 1'b0;
        case (state_reg)
            S_FETCH: imem_req = 1'b1;
            S_EXECUTE: begin
                if (ir_reg != EBREAK_INSN && !dec_memory_we && !dec_load_memory) begin
                    pc_we  = 1'b1;
                    reg_we = dec_reg_we;
                    retire = 1'b1;
                end
            end
            S_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = dec_memory_we;
                if (dmem_ready) begin
                    pc_we  = 1'b1;
                    reg_we = dec_reg_we & dec_load_memory;
                    retire = 1'b1;
                end
            end
            S_HALT:  halted = 1'b1;
            S_ERROR: error  = 1'b1;
            default: ;
        endcase
    end

    assign instruction = ir_reg;
    assign instret     = instret_reg;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: ALU/store/load sequencing, EBREAK halt, timeout, async reset.
module tb_multicycle_sequencer;

    localparam logic [31:0] NOP_INSN    = 32'h0000_0013;
    localparam logic [31:0] ADDI_INSN   = 32'h0010_0093;
    localparam logic [31:0] SW_INSN     = 32'h0020_a023;
    localparam logic [31:0] LW_INSN     = 32'h0000_a103;
    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        dec_memory_we;
    logic        dec_load_memory;
    logic        dec_reg_we;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        reg_we;
    logic        pc_we;
    logic        retire;
    logic [31:0] instret;
    logic        halted;
    logic        error;

    int checks_total  = 0;
    int checks_passed = 0;

    multicycle_sequencer #(.MEM_TIMEOUT(4), .INSTRET_WIDTH(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .instruction     (instruction),
        .dec_memory_we   (dec_memory_we),
        .dec_load_memory (dec_load_memory),
        .dec_reg_we      (dec_reg_we),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_ready      (dmem_ready),
        .reg_we          (reg_we),
        .pc_we           (pc_we),
        .retire          (retire),
        .instret         (instret),
        .halted          (halted),
        .error           (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        if (observed === expected) begin
            checks_passed++;
            $display("check %-22s got %08h exp %08h ok", tag, observed, expected);
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic mw, input logic ld, input logic rw);
        dec_memory_we   = mw;
        dec_load_memory = ld;
        dec_reg_we      = rw;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = ADDI_INSN;
        dmem_ready = 1'b0;
        set_dec(1'b0, 1'b0, 1'b1);
        step();

        // Reset state
        check("rst_imem_req", imem_req, 0);
        check("rst_ir_nop", instruction, NOP_INSN);
        check("rst_instret", instret, 0);
        check("rst_pc_we", pc_we, 0);
        check("rst_reg_we", reg_we, 0);
        check("rst_halted", halted, 0);
        check("rst_error", error, 0);
        rst_n = 1'b1;
        #1;

        // ADDI stream, imem_ready tied high
        check("idle_imem_req", imem_req, 0);
        step();
        check("fetch_imem_req", imem_req, 1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("addi_retire_%0d", i), retire, (i % 2 == 1) ? 1 : 0);
            check($sformatf("addi_pc_we_%0d", i), pc_we, (i % 2 == 1) ? 1 : 0);
            check($sformatf("addi_reg_we_%0d", i), reg_we, (i % 2 == 1) ? 1 : 0);
            step();
        end
        check("addi_instret", instret, 4);
        check("addi_ir", instruction, ADDI_INSN);

        // SW with dmem_ready delayed 3 cycles (now in FETCH)
        imem_rdata = SW_INSN;
        set_dec(1'b1, 1'b0, 1'b0);
        step();
        check("sw_exec_retire", retire, 0);
        check("sw_exec_pc_we", pc_we, 0);
        check("sw_exec_dmem_req", dmem_req, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            dmem_ready = (i == 3);
            #1;
            check($sformatf("sw_dmem_req_%0d", i), dmem_req, 1);
            check($sformatf("sw_dmem_we_%0d", i), dmem_we, 1);
            check($sformatf("sw_reg_we_%0d", i), reg_we, 0);
            check($sformatf("sw_retire_%0d", i), retire, (i == 3) ? 1 : 0);
            check($sformatf("sw_pc_we_%0d", i), pc_we, (i == 3) ? 1 : 0);
            step();
        end
        dmem_ready = 1'b0;
        #1;
        check("sw_back_fetch", imem_req, 1);
        check("sw_error", error, 0);
        check("sw_instret", instret, 5);

        // LW with zero-wait data memory; dmem_ready held high outside MEMORY is ignored
        imem_rdata = LW_INSN;
        set_dec(1'b0, 1'b1, 1'b1);
        dmem_ready = 1'b1;
        #1;
        check("lw_fetch_dmem_req", dmem_req, 0);
        check("lw_fetch_retire", retire, 0);
        step();
        check("lw_exec_reg_we", reg_we, 0);
        check("lw_exec_pc_we", pc_we, 0);
        step();
        check("lw_mem_reg_we", reg_we, 1);
        check("lw_mem_pc_we", pc_we, 1);
        check("lw_mem_dmem_we", dmem_we, 0);
        check("lw_mem_dmem_req", dmem_req, 1);
        step();
        check("lw_next_fetch", imem_req, 1);
        check("lw_next_reg_we", reg_we, 0);
        check("lw_instret", instret, 6);
        dmem_ready = 1'b0;

        // EBREAK
        imem_rdata = EBREAK_INSN;
        set_dec(1'b0, 1'b0, 1'b0);
        step();
        check("ebrk_exec_retire", retire, 0);
        check("ebrk_exec_pc_we", pc_we, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            imem_ready = (i == 1);
            #1;
            check($sformatf("halt_halted_%0d", i), halted, 1);
            check($sformatf("halt_imem_req_%0d", i), imem_req, 0);
            check($sformatf("halt_pc_we_%0d", i), pc_we, 0);
            step();
        end
        check("halt_instret", instret, 6);
        imem_ready = 1'b1;
        imem_rdata = ADDI_INSN;
        set_dec(1'b0, 1'b0, 1'b1);
        do_reset();
        check("halt_rst_halted", halted, 0);
        check("halt_rst_instret", instret, 0);
        check("halt_rst_ir", instruction, NOP_INSN);
        check("halt_rst_idle_req", imem_req, 0);
        step();
        check("halt_rst_fetch", imem_req, 1);
        step();
        check("halt_rst_retire", retire, 1);

        // Fetch timeout: MEM_TIMEOUT=4, imem_ready held low
        imem_ready = 1'b0;
        do_reset();
        step();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("to_fetch_req_%0d", i), imem_req, 1);
            check($sformatf("to_fetch_err_%0d", i), error, 0);
            step();
        end
        check("to_error", error, 1);
        check("to_imem_req", imem_req, 0);
        check("to_ir_held", instruction, NOP_INSN);
        step();
        check("to_error_sticky", error, 1);

        // Ready on the 4th fetch cycle wins
        do_reset();
        step();
        for (int i = 0; i < 4; i++) begin
            imem_ready = (i == 3);
            step();
        end
        imem_ready = 1'b0;
        #1;
        check("to_edge_error", error, 0);
        check("to_edge_retire", retire, 1);
        check("to_edge_ir", instruction, ADDI_INSN);

        // Async reset during a pending store
        imem_ready = 1'b1;
        imem_rdata = SW_INSN;
        set_dec(1'b1, 1'b0, 1'b0);
        dmem_ready = 1'b0;
        do_reset();
        step();
        step();
        step();
        check("rstmem_dmem_req", dmem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmem_req_drop", dmem_req, 0);
        check("rstmem_retire", retire, 0);
        check("rstmem_instret", instret, 0);
        step();
        rst_n = 1'b1;
        #1;
        check("rstmem_idle", imem_req, 0);
        step();
        check("rstmem_fetch", imem_req, 1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle FSM that sequences the single-cycle datapath (decoder/control unit, ALU, register file, PC) across FETCH, EXECUTE and MEMORY phases.
- Talks to instruction and data memories with req/ready handshakes.
- Gates the decoder's raw write enables (register file, data memory, PC) so that each instruction commits exactly once.
- Sits between the control unit outputs and the state elements; also detects EBREAK, memory timeouts and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 16: max wait cycles for a ready before the ERROR state; 0 disables the timeout.
- INSTRET_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  fetch data valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- instruction  out  32  latched instruction register (IR); drives the control unit.
- dec_memory_we  in  1  decoded store.
- dec_load_memory  in  1  decoded load.
- dec_reg_we  in  1  decoded register write.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write qualifier (valid with dmem_req).
- dmem_ready  in  1  data access complete.
- reg_we  out  1  gated register-file write enable.
- pc_we  out  1  PC update enable; PC takes pc_src selection.
- retire  out  1  one-cycle pulse per committed instruction.
- instret  out  INSTRET_WIDTH  retired-instruction count.
- halted  out  1  EBREAK reached (sticky).
- error  out  1  memory timeout (sticky).

Behaviour:
- States: IDLE, FETCH, EXECUTE, MEMORY, HALT, ERROR.
- Reset (rst_n low, asynchronous):
  - State is IDLE.
  - IR = 32'h00000013 (NOP); instret = 0; wait counter = 0.
  - All outputs are 0.
- IDLE: no outputs asserted; goes to FETCH on the next clk.
- FETCH:
  - imem_req = 1 every cycle in the state.
  - On imem_ready, IR <= imem_rdata and the state goes to EXECUTE.
  - imem_rdata is ignored when imem_ready = 0.
- EXECUTE (exactly one cycle):
  - If IR == 32'h00100073 (EBREAK): go to HALT; no pc_we, no retire.
  - Else if dec_memory_we or dec_load_memory: go to MEMORY; no commit this cycle.
  - Else: pc_we = 1, reg_we = dec_reg_we, retire = 1, then go to FETCH.
- MEMORY:
  - dmem_req = 1 and dmem_we = dec_memory_we, both held constant until dmem_ready.
  - On dmem_ready: pc_we = 1, reg_we = dec_reg_we & dec_load_memory, retire = 1, then go to FETCH.
  - Loads therefore write back in the ready cycle; read data must be valid with dmem_ready.
- Outputs are a combinational function of state, decoded inputs and ready signals. reg_we, pc_we and dmem_req are never asserted in IDLE, FETCH, HALT or ERROR.
- Latency:
  - ALU instruction: 1 + fetch wait + 1 cycles.
  - Load/store: additionally 1 + data wait cycles.
  - With zero-wait memories: ALU = 2 cycles, load/store = 3 cycles.
- Timeout:
  - The wait counter clears on entry to FETCH/MEMORY and increments each cycle without ready.
  - If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT - 1 while ready is still 0, the next state is ERROR.
  - A ready arriving in that same cycle wins, and normal completion occurs.
- HALT and ERROR are terminal until reset; halted/error are 1 in those states only. ERROR holds the IR of the faulting instruction.
- instret increments on every retire and wraps modulo 2^INSTRET_WIDTH.
- Reset mid-transaction: requests drop immediately (asynchronously), no commit, restart from IDLE.
- imem_ready or dmem_ready asserted outside its requesting state is ignored.

Test Plan:
- ADDI stream, imem_ready tied 1: imem_req high cycle after reset; retire every 2nd cycle; instret = 4 after 8 cycles; reg_we and pc_we pulse with retire.
- SW with dmem_ready delayed 3 cycles: dmem_req = 1 and dmem_we = 1 held for 4 cycles; reg_we stays 0; a single pc_we/retire in the ready cycle.
- LW with dmem_ready = 1: reg_we = 1 and pc_we = 1 in the MEMORY cycle only; total 3 cycles per instruction; dmem_we = 0.
- Fetch EBREAK (32'h00100073): halted = 1 from the next cycle, with pc_we, retire and imem_req 0 thereafter. Pulse imem_ready, still halted. Pulse rst_n low, then normal fetch resumes.
- MEM_TIMEOUT = 4, imem_ready held 0: error = 1 after exactly 4 FETCH cycles. A second run with ready on the 4th cycle completes normally.
- Assert rst_n low during MEMORY with a store pending: dmem_req drops the same cycle (asynchronously); no retire; instret = 0; restarts IDLE then FETCH.
